// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: autonomous scan controller for an 8-channel, 12-bit SPI ADC
// (LTC2308-style CONVST/SCK/SDI/SDO). Cycles through channels 0..LAST_CH and runs one
// conversion plus one 12-bit transfer per frame. Results land in per-channel registers
// that are readable over an Avalon-MM slave.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   avs_address/read/write/writedata/readdata
//                       Avalon-MM slave, registered read data, 1-cycle read latency
//   adc_sclk            serial clock, idles low
//   adc_cs_n            high = convert, low = transfer
//   adc_din             6-bit config word, MSB first, changes on SCLK falling edges
//   adc_dout            12-bit result, MSB first, sampled on SCLK rising edges
//   scan_done           one-cycle pulse after the last channel of a pass is stored
//   irq                 DONE & IE, registered (only when ADC_SCAN_IRQ_EN is defined)
//
// Build option: define ADC_SCAN_IRQ_EN to add the irq output and the CTRL.IE bit.
module adc_scan_sequencer #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CONV_WAIT = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic        scan_done
`ifdef ADC_SCAN_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CwW = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StShift, StStore} state_e;

  state_e          state_q, state_d;
  logic [CwW-1:0]  conv_cnt_q, conv_cnt_d;
  logic [7:0]      div_cnt_q, div_cnt_d;
  logic [4:0]      edge_cnt_q, edge_cnt_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic [11:0]     tx_sh_q, tx_sh_d;
  logic [11:0]     rx_sh_q, rx_sh_d;
  // Channel programmed by the current frame, and the one whose result it returns.
  logic [2:0]      ch_ptr_q, ch_ptr_d;
  logic [2:0]      prev_ch_q, prev_ch_d;
  logic            prev_valid_q, prev_valid_d;
  logic            prev_last_q, prev_last_d;
  // Pass configuration, captured from CTRL whenever the pointer restarts at 0.
  logic [2:0]      last_ch_q, last_ch_d;
  logic            uni_q, uni_d;
  logic            ctrl_en_q, ctrl_en_d;
  logic [2:0]      ctrl_last_ch_q, ctrl_last_ch_d;
  logic            ctrl_uni_q, ctrl_uni_d;
  logic [11:0]     result_q [8];
  logic [11:0]     result_d [8];
  logic [7:0]      valid_q, valid_d;
  logic [7:0]      pass_cnt_q, pass_cnt_d;
  logic            done_q, done_d;
  logic            done_set, done_clr;
  logic            scan_done_q, scan_done_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ctrl_ie;

`ifdef ADC_SCAN_IRQ_EN
  logic ctrl_ie_q, ctrl_ie_d;
  logic irq_q;
  assign ctrl_ie = ctrl_ie_q;
  assign irq     = irq_q;
`else
  assign ctrl_ie = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^{avs_writedata[31:17], avs_writedata[15:9], avs_writedata[7],
                          avs_writedata[3:1]};

  always_comb begin
    state_d        = state_q;
    conv_cnt_d     = conv_cnt_q;
    div_cnt_d      = div_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    sclk_d         = sclk_q;
    cs_n_d         = cs_n_q;
    tx_sh_d        = tx_sh_q;
    rx_sh_d        = rx_sh_q;
    ch_ptr_d       = ch_ptr_q;
    prev_ch_d      = prev_ch_q;
    prev_valid_d   = prev_valid_q;
    prev_last_d    = prev_last_q;
    last_ch_d      = last_ch_q;
    uni_d          = uni_q;
    ctrl_en_d      = ctrl_en_q;
    ctrl_last_ch_d = ctrl_last_ch_q;
    ctrl_uni_d     = ctrl_uni_q;
    result_d       = result_q;
    valid_d        = valid_q;
    pass_cnt_d     = pass_cnt_q;
    done_set       = 1'b0;
    done_clr       = 1'b0;
    scan_done_d    = 1'b0;
    rdata_d        = rdata_q;
`ifdef ADC_SCAN_IRQ_EN
    ctrl_ie_d      = ctrl_ie_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (ctrl_en_q) begin
          state_d      = StConv;
          conv_cnt_d   = '0;
          last_ch_d    = ctrl_last_ch_q;
          uni_d        = ctrl_uni_q;
          prev_valid_d = 1'b0;  // first frame after idle is a dummy
        end
      end
      StConv: begin
        if (conv_cnt_q == CwW'(CONV_WAIT - 1)) begin
          state_d    = StShift;
          cs_n_d     = 1'b0;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          // First config bit must already be on adc_din when SHIFT starts.
          tx_sh_d    = {1'b1, ch_ptr_q[0], ch_ptr_q[2], ch_ptr_q[1], uni_q, 1'b0, 6'b0};
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (div_cnt_q == 8'(CLK_DIV - 1)) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + 1'b1;
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[10:0], adc_dout};
          end else begin
            tx_sh_d = {tx_sh_q[10:0], 1'b0};
          end
          if (edge_cnt_q == 5'd23) begin
            state_d = StStore;
            cs_n_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StStore: begin
        if (prev_valid_q) begin
          result_d[prev_ch_q] = rx_sh_q;
          valid_d[prev_ch_q]  = 1'b1;
          if (prev_last_q) begin
            scan_done_d = 1'b1;
            pass_cnt_d  = pass_cnt_q + 1'b1;
            done_set    = 1'b1;
          end
        end
        prev_ch_d    = ch_ptr_q;
        prev_last_d  = (ch_ptr_q == last_ch_q);
        prev_valid_d = 1'b1;
        if (ctrl_en_q) begin
          state_d    = StConv;
          conv_cnt_d = '0;
          if (ch_ptr_q == last_ch_q) begin
            ch_ptr_d  = '0;
            last_ch_d = ctrl_last_ch_q;
            uni_d     = ctrl_uni_q;
          end else begin
            ch_ptr_d = ch_ptr_q + 1'b1;
          end
        end else begin
          state_d      = StIdle;
          ch_ptr_d     = '0;
          prev_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (avs_write) begin
      if (avs_address == 4'd8) begin
        ctrl_en_d      = avs_writedata[0];
        ctrl_last_ch_d = avs_writedata[6:4];
        ctrl_uni_d     = avs_writedata[8];
`ifdef ADC_SCAN_IRQ_EN
        ctrl_ie_d      = avs_writedata[1];
`endif
      end else if (avs_address == 4'd9) begin
        done_clr = avs_writedata[16];
      end
    end
    // Set wins over a same-cycle clear.
    done_d = (done_q & ~done_clr) | done_set;

    // Read mux samples pre-update state, so a colliding store reads as the old value.
    if (avs_read) begin
      if (avs_address < 4'd8) begin
        rdata_d = {valid_q[avs_address[2:0]], 19'b0, result_q[avs_address[2:0]]};
      end else if (avs_address == 4'd8) begin
        rdata_d = {23'b0, ctrl_uni_q, 1'b0, ctrl_last_ch_q, 2'b00, ctrl_ie, ctrl_en_q};
      end else if (avs_address == 4'd9) begin
        rdata_d = {15'b0, done_q, pass_cnt_q, 7'b0, (state_q != StIdle)};
      end else begin
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      conv_cnt_q     <= '0;
      div_cnt_q      <= '0;
      edge_cnt_q     <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      tx_sh_q        <= '0;
      rx_sh_q        <= '0;
      ch_ptr_q       <= '0;
      prev_ch_q      <= '0;
      prev_valid_q   <= 1'b0;
      prev_last_q    <= 1'b0;
      last_ch_q      <= '0;
      uni_q          <= 1'b1;
      ctrl_en_q      <= 1'b0;
      ctrl_last_ch_q <= '0;
      ctrl_uni_q     <= 1'b1;
      for (int i = 0; i < 8; i++) result_q[i] <= '0;
      valid_q        <= '0;
      pass_cnt_q     <= '0;
      done_q         <= 1'b0;
      scan_done_q    <= 1'b0;
      rdata_q        <= '0;
`ifdef ADC_SCAN_IRQ_EN
      ctrl_ie_q      <= 1'b0;
      irq_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      conv_cnt_q     <= conv_cnt_d;
      div_cnt_q      <= div_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      sclk_q         <= sclk_d;
      cs_n_q         <= cs_n_d;
      tx_sh_q        <= tx_sh_d;
      rx_sh_q        <= rx_sh_d;
      ch_ptr_q       <= ch_ptr_d;
      prev_ch_q      <= prev_ch_d;
      prev_valid_q   <= prev_valid_d;
      prev_last_q    <= prev_last_d;
      last_ch_q      <= last_ch_d;
      uni_q          <= uni_d;
      ctrl_en_q      <= ctrl_en_d;
      ctrl_last_ch_q <= ctrl_last_ch_d;
      ctrl_uni_q     <= ctrl_uni_d;
      for (int i = 0; i < 8; i++) result_q[i] <= result_d[i];
      valid_q        <= valid_d;
      pass_cnt_q     <= pass_cnt_d;
      done_q         <= done_d;
      scan_done_q    <= scan_done_d;
      rdata_q        <= rdata_d;
`ifdef ADC_SCAN_IRQ_EN
      ctrl_ie_q      <= ctrl_ie_d;
      irq_q          <= done_q & ctrl_ie_q;
`endif
    end
  end

  assign adc_sclk     = sclk_q;
  assign adc_cs_n     = cs_n_q;
  assign adc_din      = tx_sh_q[11];
  assign avs_readdata = rdata_q;
  assign scan_done    = scan_done_q;

endmodule
